psum_drain_ctrl: RTL and testbench

//  Drains one column of output-stationary PEs after accumulation.

---
 rtl/axon_pkg.sv | 13 +
 rtl/psum_drain_ctrl_if.sv | 24 ++
 rtl/psum_drain_ctrl.sv | 125 ++++++++++++
 tb/tb_psum_drain_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axon_pkg.sv
// Shared definitions for the array output path: drain FSM state encoding and default data width.
package axon_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_CLEAR = 2'd3
    } drain_state_e;

endpackage

// File: rtl/psum_drain_ctrl_if.sv
// Output-BRAM write port: one request slot with a valid/ready handshake.
interface psum_drain_ctrl_if #(
    parameter int DW     = 16,
    parameter int ADDR_W = 10
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/psum_drain_ctrl.sv
// Drains one output-stationary PE column into output BRAM through a single-entry write slot,
// with optional ReLU, then pulses clear_psum to the column.
module psum_drain_ctrl
    import axon_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int N_ROWS = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              relu_en,
    input  logic [DW-1:0]     drain_in,
    output logic              eject_ctrl,
    output logic              pe_en_out,
    output logic              clear_psum,
    output logic              busy,
    output logic              done,
    psum_drain_ctrl_if.master wr
);

    localparam int                CNT_W    = $clog2(N_ROWS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ROWS - 1);

    drain_state_e      state_q, state_d;
    logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              relu_q, relu_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;

    logic shift;
    logic accept;

    function automatic logic [DW-1:0] apply_relu(input logic [DW-1:0] x, input logic en);
        return (en && x[DW-1]) ? '0 : x;
    endfunction

    // The chain only advances when the slot can take the word it produces.
    assign shift  = (state_q == ST_DRAIN) && (!valid_q || wr.wr_ready);
    assign accept = valid_q && wr.wr_ready;

    assign eject_ctrl  = shift;
    assign pe_en_out   = shift;
    assign clear_psum  = (state_q == ST_CLEAR);
    assign done        = (state_q == ST_CLEAR);
    assign busy        = (state_q != ST_IDLE);

    assign wr.wr_valid = valid_q;
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = data_q;

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        base_d      = base_q;
        relu_d      = relu_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;

        if (shift) begin
            valid_d = 1'b1;
            data_d  = apply_relu(drain_in, relu_q);
            addr_d  = base_q + ADDR_W'(shift_cnt_q);
        end else if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_DRAIN;
                    base_d      = base_addr;
                    relu_d      = relu_en;
                    shift_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (shift) begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    if (shift_cnt_q == LAST_CNT) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (!valid_q || wr.wr_ready) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset aborts a drain in place: the slot is dropped and the PEs are not cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            base_q      <= '0;
            relu_q      <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            base_q      <= base_d;
            relu_q      <= relu_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Self-checking bench for psum_drain_ctrl: a queue models the PE column tail, a scoreboard checks BRAM writes.
module tb_psum_drain_ctrl;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          relu_en;
    logic [DW-1:0] drain_in;
    logic          eject_ctrl;
    logic          pe_en_out;
    logic          clear_psum;
    logic          busy;
    logic          done;

    psum_drain_ctrl_if #(.DW(DW), .ADDR_W(AW)) wr_if ();

    psum_drain_ctrl #(.DW(DW), .N_ROWS(N), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .relu_en    (relu_en),
        .drain_in   (drain_in),
        .eject_ctrl (eject_ctrl),
        .pe_en_out  (pe_en_out),
        .clear_psum (clear_psum),
        .busy       (busy),
        .done       (done),
        .wr         (wr_if.master)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] chain_q[$];
    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    int            shifts, clears, dones, done_cyc, first_acc, last_acc, first_v, start_cyc;
    logic          hold_pend;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic          s_ej;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs before the edge, then advance the modelled PE chain.
    task automatic tick();
        #1;
        s_ej = eject_ctrl;
        if (eject_ctrl || pe_en_out) check("ej_en_match", 32'(pe_en_out), 32'(eject_ctrl));
        if (hold_pend) begin
            check("bp_valid", 32'(wr_if.wr_valid), 32'(1));
            check("bp_addr", 32'(wr_if.wr_addr), 32'(hold_addr));
            check("bp_data", 32'(wr_if.wr_data), 32'(hold_data));
        end
        if (wr_if.wr_valid && !wr_if.wr_ready) begin
            check("bp_noshift", 32'(eject_ctrl), 32'(0));
            hold_pend = 1'b1;
            hold_addr = wr_if.wr_addr;
            hold_data = wr_if.wr_data;
        end else begin
            hold_pend = 1'b0;
        end
        if (wr_if.wr_valid && wr_if.wr_ready) begin
            got_addr.push_back(wr_if.wr_addr);
            got_data.push_back(wr_if.wr_data);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (clear_psum || done) check("clr_done_sync", 32'(clear_psum), 32'(done));
        if (clear_psum) clears++;
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (s_ej && rst) begin
            shifts++;
            if (chain_q.size() > 0) void'(chain_q.pop_front());
            drain_in = (chain_q.size() > 0) ? chain_q[0] : 16'hDEAD;
        end else if (s_ej) begin
            if (chain_q.size() > 0) void'(chain_q.pop_front());
            drain_in = (chain_q.size() > 0) ? chain_q[0] : 16'hDEAD;
        end
        @(negedge clk);
    endtask

    task automatic clear_book();
        shifts = 0; clears = 0; dones = 0; done_cyc = -1;
        first_acc = -1; last_acc = -1; first_v = -1;
        got_addr.delete();
        got_data.delete();
        hold_pend = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready; 2: 5-cycle stall after first capture; 3: spurious starts
    task automatic run_drain(input string tag, input logic [AW-1:0] base, input logic relu,
                             input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                             input logic [DW-1:0] v2, input logic [DW-1:0] v3,
                             input int mode, input int idle_after);
        logic [DW-1:0] vals[N];
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        chain_q = {v0, v1, v2, v3};
        drain_in = v0;
        clear_book();
        base_addr = base;
        relu_en = relu;
        start = 1'b1;
        wr_if.wr_ready = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        base_addr = ~base;
        relu_en = ~relu;
        check({tag, "/busy"}, 32'(busy), 32'(1));
        for (int i = 0; i < 200 && dones == 0; i++) begin
            if (wr_if.wr_valid && first_v < 0) first_v = cyc;
            case (mode)
                1: wr_if.wr_ready = 1'($urandom_range(0, 1));
                2: wr_if.wr_ready = (first_v >= 0 && cyc < first_v + 5) ? 1'b0 : 1'b1;
                3: begin
                    wr_if.wr_ready = 1'b1;
                    start = (cyc == start_cyc + 2) || clear_psum;
                end
                default: wr_if.wr_ready = 1'b1;
            endcase
            tick();
        end
        start = 1'b0;
        wr_if.wr_ready = 1'b1;
        for (int i = 0; i < idle_after; i++) tick();

        check({tag, "/n_writes"}, 32'(got_addr.size()), 32'(N));
        for (int k = 0; k < N; k++) begin
            e_addr = base + AW'(k);
            e_data = (relu && vals[k][DW-1]) ? '0 : vals[k];
            if (k < got_addr.size()) begin
                check($sformatf("%s/addr%0d", tag, k), 32'(got_addr[k]), 32'(e_addr));
                check($sformatf("%s/data%0d", tag, k), 32'(got_data[k]), 32'(e_data));
            end
        end
        check({tag, "/shifts"}, 32'(shifts), 32'(N));
        check({tag, "/clears"}, 32'(clears), 32'(1));
        check({tag, "/dones"}, 32'(dones), 32'(1));
        check({tag, "/done_after_last"}, 32'(done_cyc), 32'(last_acc + 1));
        check({tag, "/first_valid_lat"}, 32'(first_v - start_cyc), 32'(2));
        if (mode != 1) check({tag, "/burst"}, 32'(last_acc - first_acc), 32'(N - 1));
        if (mode == 0 || mode == 3) check({tag, "/first_acc_lat"}, 32'(first_acc - start_cyc), 32'(2));
        if (mode == 2) check({tag, "/stall_acc_lat"}, 32'(first_acc - start_cyc), 32'(7));
        if (idle_after > 0) check({tag, "/idle_busy"}, 32'(busy), 32'(0));
        $display("drain %s base=0x%03h relu=%0d mode=%0d writes=%0d shifts=%0d",
                 tag, base, relu, mode, got_addr.size(), shifts);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        base_addr = '0;
        relu_en = 1'b0;
        drain_in = '0;
        wr_if.wr_ready = 1'b0;
        clear_book();
        @(negedge clk);
        tick();
        tick();
        check("rst/busy", 32'(busy), 32'(0));
        check("rst/wr_valid", 32'(wr_if.wr_valid), 32'(0));
        check("rst/wr_addr", 32'(wr_if.wr_addr), 32'(0));
        check("rst/wr_data", 32'(wr_if.wr_data), 32'(0));
        check("rst/eject", 32'(eject_ctrl), 32'(0));
        check("rst/pe_en", 32'(pe_en_out), 32'(0));
        check("rst/clear", 32'(clear_psum), 32'(0));
        check("rst/done", 32'(done), 32'(0));
        rst = 1'b1;
        tick();

        run_drain("basic", 10'h010, 1'b0, 16'd5, 16'hFFFD, 16'd7, 16'd9, 0, 1);
        run_drain("relu", 10'h010, 1'b1, 16'd5, 16'hFFFD, 16'd7, 16'd9, 0, 1);
        run_drain("relu_edge", 10'h020, 1'b1, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 0, 1);
        run_drain("stall", 10'h040, 1'b0, 16'h1234, 16'h8765, 16'h0001, 16'hFFFE, 2, 1);
        run_drain("wrap", 10'h3FE, 1'b0, 16'd11, 16'd22, 16'd33, 16'd44, 0, 1);
        run_drain("spurious", 10'h100, 1'b1, 16'hF000, 16'd1, 16'hFFFF, 16'd2, 3, 0);
        run_drain("back2back", 10'h200, 1'b0, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 0, 1);
        for (int r = 0; r < 6; r++) begin
            run_drain($sformatf("rand%0d", r), AW'($urandom), 1'($urandom_range(0, 1)),
                      DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 1, 1);
        end

        // Abort with reset while the third word is being shifted out.
        clear_book();
        chain_q = {16'd1, 16'd2, 16'd3, 16'd4};
        drain_in = 16'd1;
        base_addr = 10'h080;
        relu_en = 1'b0;
        wr_if.wr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort/shift2_eject", 32'(eject_ctrl), 32'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort/busy", 32'(busy), 32'(0));
        check("abort/wr_valid", 32'(wr_if.wr_valid), 32'(0));
        check("abort/eject", 32'(eject_ctrl), 32'(0));
        for (int i = 0; i < 4; i++) tick();
        check("abort/clears", 32'(clears), 32'(0));
        check("abort/dones", 32'(dones), 32'(0));
        $display("abort writes=%0d clears=%0d dones=%0d", got_addr.size(), clears, dones);

        run_drain("after_abort", 10'h0C0, 1'b0, 16'd100, 16'd200, 16'd300, 16'd400, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
